// File: rtl/dp_mem_p.sv
// Parametrised dual-port memory with per-entry valid flags, read handshake and optional output stage.
// Optional same-edge write-to-read forwarding is enabled by defining DP_MEM_BYPASS_EN.
module dp_mem_p #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 128,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_adr,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [ADDR_W:0]   count,
  output logic              err_oob
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  vld_nxt;
  logic [ADDR_W:0]   count_nxt;

  logic              wr_in;
  logic              rd_in;
  logic              wr_ok;
  logic              rd_ok;
  logic              cnt_inc;

  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_data;

  logic              s1_valid;
  logic              s1_hit;
  logic [DATA_W-1:0] s1_data;

  assign wr_in = ({1'b0, wr_adr} < DEPTH_L);
  assign rd_in = ({1'b0, rd_adr} < DEPTH_L);
  assign wr_ok = wr_en && wr_in;
  assign rd_ok = rd_en && rd_in;

  // Storage is deliberately not reset; the valid flags decide what reads as a hit.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_adr] <= wr_data;
    end
  end

  always_comb begin
    vld_nxt = clr ? '0 : vld;
    cnt_inc = 1'b0;
    if (wr_ok) begin
      vld_nxt[wr_adr] = 1'b1;
      cnt_inc         = !vld[wr_adr];
    end
    // A write at the clearing edge lands after the clear.
    if (clr) begin
      count_nxt = (ADDR_W+1)'(wr_ok);
    end else begin
      count_nxt = count + (ADDR_W+1)'(cnt_inc);
    end
  end

  always_comb begin
    rsp_hit  = 1'b0;
    rsp_data = '0;
    if (rd_ok) begin
`ifdef DP_MEM_BYPASS_EN
      if (wr_ok && (wr_adr == rd_adr)) begin
        rsp_hit  = 1'b1;
        rsp_data = wr_data;
      end else begin
        rsp_hit  = vld[rd_adr];
        rsp_data = vld[rd_adr] ? mem[rd_adr] : '0;
      end
`else
      rsp_hit  = vld[rd_adr];
      rsp_data = vld[rd_adr] ? mem[rd_adr] : '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld      <= '0;
      count    <= '0;
      err_oob  <= 1'b0;
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_data  <= '0;
    end else begin
      vld      <= vld_nxt;
      count    <= count_nxt;
      err_oob  <= (wr_en && !wr_in) || (rd_en && !rd_in);
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_hit  <= rsp_hit;
        s1_data <= rsp_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_valid;
      logic              s2_hit;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_hit   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_hit  <= s1_hit;
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid = s2_valid;
      assign rd_hit   = s2_hit;
      assign rd_data  = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign rd_hit   = s1_hit;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_dp_mem_p.sv
// Randomised self-checking bench for dp_mem_p: two instances (OUT_REG 0 and 1) share stimulus
// and are compared against a flag/array reference model.
module tb_dp_mem_p;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_adr;
  logic              clr;

  logic [DATA_W-1:0] rd_data0, rd_data1;
  logic              rd_valid0, rd_valid1;
  logic              rd_hit0, rd_hit1;
  logic [ADDR_W:0]   count0, count1;
  logic              err0, err1;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc          = 0;

  always #5 clk = ~clk;

  dp_mem_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_adr(rd_adr), .clr(clr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_hit(rd_hit0), .count(count0), .err_oob(err0)
  );

  dp_mem_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_adr(rd_adr), .clr(clr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_hit(rd_hit1), .count(count1), .err_oob(err1)
  );

  // Reference state: word array, valid set, and the response each instance should present.
  logic [DATA_W-1:0] mem_m [128];
  logic [127:0]      vld_m;
  int unsigned       cnt_m;
  logic              err_m;
  logic              v0, h0, v1, h1;
  logic [DATA_W-1:0] d0, d1;
  logic              p_req, p_hit;
  logic [DATA_W-1:0] p_dat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic              r_hit;
    logic [DATA_W-1:0] r_dat;
    logic              w_in, r_in;
    if (!rst_n) begin
      vld_m = '0;
      cnt_m = 0;
      err_m = 1'b0;
      v0 = 1'b0; h0 = 1'b0; d0 = '0;
      v1 = 1'b0; h1 = 1'b0; d1 = '0;
      p_req = 1'b0; p_hit = 1'b0; p_dat = '0;
      return;
    end
    w_in  = (int'(wr_adr) < DEPTH);
    r_in  = (int'(rd_adr) < DEPTH);
    r_hit = 1'b0;
    r_dat = '0;
    if (rd_en && r_in) begin
      r_hit = vld_m[rd_adr];
      r_dat = r_hit ? mem_m[rd_adr] : '0;
`ifdef DP_MEM_BYPASS_EN
      if (wr_en && w_in && (wr_adr == rd_adr)) begin
        r_hit = 1'b1;
        r_dat = wr_data;
      end
`endif
    end
    err_m = (wr_en && !w_in) || (rd_en && !r_in);
    if (clr) vld_m = '0;
    if (wr_en && w_in) begin
      mem_m[wr_adr] = wr_data;
      vld_m[wr_adr] = 1'b1;
    end
    cnt_m = $countones(vld_m);
    // Two-cycle instance presents the response from one edge earlier.
    v1 = p_req;
    if (p_req) begin h1 = p_hit; d1 = p_dat; end
    v0 = rd_en;
    if (rd_en) begin h0 = r_hit; d0 = r_dat; end
    p_req = rd_en;
    if (rd_en) begin p_hit = r_hit; p_dat = r_dat; end
  endtask

  task automatic check_all();
    check("valid0", 64'(rd_valid0), 64'(v0));
    check("hit0",   64'(rd_hit0),   64'(h0));
    check("data0",  rd_data0,       d0);
    check("count0", 64'(count0),    64'(cnt_m));
    check("err0",   64'(err0),      64'(err_m));
    check("valid1", 64'(rd_valid1), 64'(v1));
    check("hit1",   64'(rd_hit1),   64'(h1));
    check("data1",  rd_data1,       d1);
    check("count1", 64'(count1),    64'(cnt_m));
    check("err1",   64'(err1),      64'(err_m));
  endtask

  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic re, input logic [ADDR_W-1:0] ra, input logic cl, input logic rn);
    wr_en = we; wr_adr = wa; wr_data = wd;
    rd_en = re; rd_adr = ra; clr = cl; rst_n = rn;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, a, d, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b0, '0, '0, 1'b1, a, 1'b0, 1'b1);
  endtask

  initial begin
    logic              we, re, cl, rn;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd;

    rst_n = 1'b0; wr_en = 1'b0; wr_adr = '0; wr_data = '0;
    rd_en = 1'b0; rd_adr = '0; clr = 1'b0;
    @(negedge clk);
    repeat (3) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // Miss on a fresh memory, then a basic hit.
    rd(7'd5); idle(); idle();
    wr(7'd3, 64'h0123456789ABCDEF);
    rd(7'd3); idle(); idle();

    // Rewrite does not bump count; clear together with a write leaves one entry.
    wr(7'd3, 64'h1111); wr(7'd4, 64'h2222);
    step(1'b1, 7'd7, 64'h7777, 1'b0, '0, 1'b1, 1'b1);
    rd(7'd3); rd(7'd7); idle(); idle();

    // Read at the clearing edge sees pre-clear flags.
    step(1'b0, '0, '0, 1'b1, 7'd7, 1'b1, 1'b1);
    idle(); idle();

    // Same-edge read/write collision.
    wr(7'd9, 64'h55);
    step(1'b1, 7'd9, 64'hAA, 1'b1, 7'd9, 1'b0, 1'b1);
    rd(7'd9); idle(); idle();

    // Out-of-range write and read at the same edge give one pulse.
    step(1'b1, 7'd120, 64'hDEAD, 1'b1, 7'd127, 1'b0, 1'b1);
    idle(); idle();
    step(1'b0, '0, '0, 1'b1, 7'd100, 1'b0, 1'b1);
    rd(7'd99); idle(); idle();

    // Fill every entry, then rewrite some: count stays at DEPTH.
    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), {$urandom, $urandom});
    for (int i = 0; i < 5; i++) wr(ADDR_W'(i * 7), {$urandom, $urandom});
    idle();

    // Continuous reads with reset at the 8th edge.
    for (int i = 0; i < 16; i++) wr(ADDR_W'(i), {$urandom, $urandom});
    for (int i = 0; i < 16; i++)
      step(1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b0, (i == 7) ? 1'b0 : 1'b1);
    for (int i = 0; i < 4; i++) rd(ADDR_W'(i));
    idle(); idle();

    // Randomised traffic including collisions, clears, out-of-range and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 9) < 6);
      wa = ADDR_W'($urandom_range(0, 127));
      ra = ($urandom_range(0, 5) == 0) ? wa : ADDR_W'($urandom_range(0, 127));
      wd = {$urandom, $urandom};
      cl = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 199) != 0);
      step(we, wa, wd, re, ra, cl, rn);
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
